// File: rtl/clk_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_gen_ctrl
// Purpose  : Programmable divided-clock generator with glitch-free divisor
//            switching and glitch-free stop. clk_out is a registered clock
//            with a period of 2*div_q clk cycles and a 50% duty cycle.
// Revision : 1.0 - initial release
//
// Optional feature macro: CLK_GEN_CTRL_EDGE_CNT_EN
//   defined   -> edge_cnt port and rising-edge counter are present
//   undefined -> edge_cnt port and counter are absent
//
// Ports
//   clk        in   block clock
//   rst_n      in   asynchronous active-low reset
//   run        in   level: 1 = generate clock, 0 = stop glitch-free
//   cfg_valid  in   divisor update request
//   cfg_div    in   requested half-period in clk cycles (DIV_W bits)
//   cfg_ready  out  divisor can be accepted this cycle (IDLE / RUN)
//   cfg_err    out  one-cycle pulse after a transferred cfg_div of zero
//   clk_out    out  registered generated clock
//   rise_stb   out  high in the cycle clk_out first reads 1
//   busy       out  high in any state other than IDLE
//   edge_cnt   out  count of clk_out rising edges (CNT_W bits, optional)
// ============================================================================
module clk_gen_ctrl #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             busy
`ifdef CLK_GEN_CTRL_EDGE_CNT_EN
  ,
  output logic [CNT_W-1:0] edge_cnt
`endif
);

  if (DIV_W < 1 || CNT_W < 1) begin : g_param_check
    $error("clk_gen_ctrl: DIV_W and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SWITCH = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_phase;
  logic [DIV_W-1:0] r_pend;
  logic             r_clk;
  logic             r_rise;
  logic             r_err;

  logic             w_xfer;
  logic             w_div_zero;
  logic             w_wrap;
  logic [DIV_W-1:0] w_phase_inc;

  assign cfg_ready   = (r_state == S_IDLE) || (r_state == S_RUN);
  assign busy        = (r_state != S_IDLE);
  assign w_xfer      = cfg_valid && cfg_ready;
  assign w_div_zero  = (cfg_div == '0);
  // r_div is never zero, so div-1 cannot underflow.
  assign w_wrap      = (r_phase == (r_div - DIV_W'(1)));
  assign w_phase_inc = r_phase + DIV_W'(1);

  assign clk_out  = r_clk;
  assign rise_stb = r_rise;
  assign cfg_err  = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= DIV_W'(1);
      r_phase <= '0;
      r_pend  <= '0;
      r_clk   <= 1'b0;
      r_rise  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_err  <= w_xfer && w_div_zero;
      case (r_state)
        S_IDLE: begin
          r_phase <= '0;
          r_clk   <= 1'b0;
          if (w_xfer && !w_div_zero) begin
            r_div <= cfg_div;
          end
          if (run) begin
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          if (w_xfer && !w_div_zero) begin
            // New divisor waits in r_pend until the next falling toggle.
            r_pend  <= cfg_div;
            r_state <= S_SWITCH;
            r_phase <= w_wrap ? '0 : w_phase_inc;
            if (w_wrap) begin
              r_clk  <= ~r_clk;
              r_rise <= ~r_clk;
            end
          end else if (!run) begin
            // Stopping: the current half-period always completes, and the
            // wrap that ends it leaves clk_out low.
            if (w_wrap) begin
              r_state <= S_IDLE;
              r_clk   <= 1'b0;
              r_phase <= '0;
            end else begin
              r_state <= S_STOP;
              r_phase <= w_phase_inc;
            end
          end else begin
            r_phase <= w_wrap ? '0 : w_phase_inc;
            if (w_wrap) begin
              r_clk  <= ~r_clk;
              r_rise <= ~r_clk;
            end
          end
        end

        S_SWITCH: begin
          if (w_wrap) begin
            r_phase <= '0;
            if (r_clk) begin
              // Falling toggle: safe point to adopt the new divisor.
              r_clk   <= 1'b0;
              r_div   <= r_pend;
              r_state <= run ? S_RUN : S_STOP;
            end else begin
              r_clk  <= 1'b1;
              r_rise <= 1'b1;
            end
          end else begin
            r_phase <= w_phase_inc;
          end
        end

        S_STOP: begin
          if (w_wrap) begin
            r_state <= S_IDLE;
            r_clk   <= 1'b0;
            r_phase <= '0;
          end else begin
            r_phase <= w_phase_inc;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_clk   <= 1'b0;
          r_phase <= '0;
        end
      endcase
    end
  end

`ifdef CLK_GEN_CTRL_EDGE_CNT_EN
  logic [CNT_W-1:0] r_edge_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_cnt <= '0;
    end else if (r_rise) begin
      r_edge_cnt <= r_edge_cnt + CNT_W'(1);
    end
  end

  assign edge_cnt = r_edge_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gen_ctrl
// Purpose  : Self-checking bench for clk_gen_ctrl: vector table, directed
//            corner sequences and randomized stimulus against a reference
//            model that tracks cycles remaining in each half-period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_gen_ctrl;

  localparam int DIV_W = 8;
  localparam int CNT_W = 4;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_SWITCH = 2;
  localparam int M_STOP   = 3;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             rise_stb;
  logic             busy;
`ifdef CLK_GEN_CTRL_EDGE_CNT_EN
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] m_cnt;
`endif

  int checks = 0;
  int errors = 0;

  clk_gen_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .rise_stb  (rise_stb),
    .busy      (busy)
`ifdef CLK_GEN_CTRL_EDGE_CNT_EN
    ,
    .edge_cnt  (edge_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic       valid;
    logic [7:0] div;
    logic       e_clk;
    logic       e_rise;
    logic       e_ready;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t vecs[15];

  // Reference model: mode, divisor, pending divisor, cycles left in the
  // current half-period, and expected registered outputs.
  int   m_mode;
  int   m_div;
  int   m_pend;
  int   m_left;
  logic m_out;
  logic m_rise;
  logic m_err;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_div  = 1;
    m_pend = 0;
    m_left = 0;
    m_out  = 1'b0;
    m_rise = 1'b0;
    m_err  = 1'b0;
`ifdef CLK_GEN_CTRL_EDGE_CNT_EN
    m_cnt  = '0;
`endif
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_rise_stb", rise_stb, 0);
    chk("rst_cfg_err", cfg_err, 0);
`ifdef CLK_GEN_CTRL_EDGE_CNT_EN
    chk("rst_edge_cnt", edge_cnt, 0);
`endif
  endtask

  // Advance the current half-period by one cycle; toggle when it ends.
  task automatic model_count();
    if (m_left == 1) begin
      m_out  = ~m_out;
      m_rise = m_out;
      m_left = m_div;
    end else begin
      m_left = m_left - 1;
    end
  endtask

  task automatic model_step(input logic i_run, input logic i_valid, input int i_div);
    logic ready;
    logic xfer;
    ready = (m_mode == M_IDLE) || (m_mode == M_RUN);
    xfer  = i_valid && ready;
`ifdef CLK_GEN_CTRL_EDGE_CNT_EN
    if (m_rise) m_cnt = m_cnt + 1'b1;
`endif
    m_err  = xfer && (i_div == 0);
    m_rise = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (xfer && i_div != 0) m_div = i_div;
        if (i_run) begin
          m_mode = M_RUN;
          m_left = m_div;
          m_out  = 1'b0;
        end
      end
      M_RUN: begin
        if (xfer && i_div != 0) begin
          m_pend = i_div;
          m_mode = M_SWITCH;
          model_count();
        end else if (!i_run) begin
          if (m_left == 1) begin
            m_mode = M_IDLE;
            m_out  = 1'b0;
          end else begin
            m_mode = M_STOP;
            m_left = m_left - 1;
          end
        end else begin
          model_count();
        end
      end
      M_SWITCH: begin
        if (m_left == 1 && m_out) begin
          m_out  = 1'b0;
          m_div  = m_pend;
          m_left = m_div;
          m_mode = i_run ? M_RUN : M_STOP;
        end else begin
          model_count();
        end
      end
      default: begin
        if (m_left == 1) begin
          m_mode = M_IDLE;
          m_out  = 1'b0;
        end else begin
          m_left = m_left - 1;
        end
      end
    endcase
  endtask

  task automatic wait_rise(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (rise_stb) seen = 1'b1;
    end
    chk(name, seen, 1);
  endtask

  initial begin
    int hi;
    int rises;

    // ---------------- table-driven vectors ----------------
    //          run valid div  clk rise rdy busy err
    vecs[0]  = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      run       = vecs[i].run;
      cfg_valid = vecs[i].valid;
      cfg_div   = vecs[i].div;
      tick();
      chk($sformatf("vec%0d_clk_out", i), clk_out, vecs[i].e_clk);
      chk($sformatf("vec%0d_rise_stb", i), rise_stb, vecs[i].e_rise);
      chk($sformatf("vec%0d_cfg_ready", i), cfg_ready, vecs[i].e_ready);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_cfg_err", i), cfg_err, vecs[i].e_err);
    end

    // ---------------- divisor switch 4 -> 1 while high ----------------
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd4;
    tick();
    cfg_valid = 1'b0; run = 1'b1;
    tick();
    wait_rise("sw_first_rise");
    hi = 1;
    chk("sw_ready_before", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_div = 8'd1;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 20 && clk_out; i++) begin
      hi++;
      chk("sw_ready_low", cfg_ready, 0);
      tick();
    end
    chk("sw_high_len", hi, 4);
    chk("sw_fall_clk", clk_out, 0);
    chk("sw_ready_after", cfg_ready, 1);
    tick();
    chk("sw_p2_hi", clk_out, 1);
    chk("sw_p2_rise", rise_stb, 1);
    tick();
    chk("sw_p2_lo", clk_out, 0);
    tick();
    chk("sw_p2_hi2", clk_out, 1);

    // ---------------- stop one cycle after a rise, div 5 ----------------
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd5;
    tick();
    cfg_valid = 1'b0; run = 1'b1;
    tick();
    wait_rise("stop_rise");
    hi = 1;
    run = 1'b0;
    tick();
    for (int i = 0; i < 20 && clk_out; i++) begin
      hi++;
      chk("stop_no_rise", rise_stb, 0);
      tick();
    end
    chk("stop_high_len", hi, 5);
    chk("stop_busy", busy, 0);
    chk("stop_clk_low", clk_out, 0);
    tick();
    chk("stop_idle_clk", clk_out, 0);

    // ---------------- async reset mid high phase ----------------
    do_reset();
    cfg_valid = 1'b1; cfg_div = 8'd3;
    tick();
    cfg_valid = 1'b0; run = 1'b1;
    tick();
    wait_rise("ar_rise");
    tick();
    chk("ar_high_before", clk_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_clk_forced", clk_out, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_enter_run", busy, 1);
    tick();
    chk("ar_div1_hi", clk_out, 1);
    tick();
    chk("ar_div1_lo", clk_out, 0);

`ifdef CLK_GEN_CTRL_EDGE_CNT_EN
    // ---------------- edge counter wrap ----------------
    do_reset();
    run = 1'b1;
    rises = 0;
    for (int i = 0; i < 100 && rises < 17; i++) begin
      tick();
      if (rise_stb) rises++;
    end
    chk("ec_rises", rises, 17);
    run = 1'b0;
    repeat (3) tick();
    chk("ec_wrapped", edge_cnt, 1);
`endif

    // ---------------- randomized against reference model ----------------
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_div   = 8'($urandom_range(0, 4));
      model_step(run, cfg_valid, int'(cfg_div));
      tick();
      chk("rnd_clk_out", clk_out, m_out);
      chk("rnd_rise_stb", rise_stb, m_rise);
      chk("rnd_cfg_err", cfg_err, m_err);
      chk("rnd_busy", busy, int'(m_mode != M_IDLE));
      chk("rnd_cfg_ready", cfg_ready, int'(m_mode == M_IDLE || m_mode == M_RUN));
`ifdef CLK_GEN_CTRL_EDGE_CNT_EN
      chk("rnd_edge_cnt", edge_cnt, m_cnt);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_gen_ctrl.md
CLK_GEN_CTRL -- requirements
Module: clk_gen_ctrl

Interface
REQ-001 Parameter DIV_W, default 8: width of the divisor.
REQ-002 Parameter CNT_W, default 16: width of the rising-edge counter.
REQ-003 clk  input  1: single clock for the block.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 run  input  1: level; 1 requests clock generation, 0 requests a glitch-free stop.
REQ-006 cfg_valid  input  1: divisor update request.
REQ-007 cfg_div  input  DIV_W: requested half-period in clk cycles.
REQ-008 cfg_ready  output  1: block can accept cfg_div this cycle.
REQ-009 cfg_err  output  1: one-cycle pulse when cfg_div==0 is transferred.
REQ-010 clk_out  output  1: registered generated clock.
REQ-011 rise_stb  output  1: one-cycle pulse in the cycle clk_out goes 0->1.
REQ-012 busy  output  1: high in any state other than IDLE.
REQ-013 edge_cnt  output  CNT_W: count of clk_out rising edges; present only with the macro in REQ-030.

Function
REQ-014 States SHALL be IDLE, RUN, SWITCH and STOP.
REQ-015 A transfer SHALL occur when cfg_valid && cfg_ready are both high on a clk edge.
REQ-016 cfg_ready SHALL be high in IDLE and RUN, and low in SWITCH and STOP.
REQ-017 In IDLE, a transferred nonzero cfg_div SHALL load div_q on the same edge.
REQ-018 A transferred cfg_div==0 SHALL leave div_q unchanged, pulse cfg_err on the next cycle, and cause no state change.
REQ-019 IDLE->RUN SHALL occur when run==1; the phase counter clears to 0 and clk_out is held at 0.
REQ-020 In RUN, the phase counter SHALL increment each cycle.
  - At phase==div_q-1: clk_out toggles and the phase counter clears.
  - Period is exactly 2*div_q clk cycles; duty cycle is 50%.
REQ-021 In RUN, a transferred nonzero cfg_div SHALL be held pending and the state moves to SWITCH.
REQ-022 In SWITCH, counting continues with the old div_q.
  - At the first toggle that drives clk_out 1->0, div_q takes the pending value and the phase clears.
  - The state returns to RUN (or STOP if run==0), so no clk_out pulse is ever shorter than min(old,new) half-period.
REQ-023 When run==0 in RUN, the state SHALL go to STOP; counting continues.
  - If clk_out is already 0, clk_out stays 0 and the state enters IDLE at the next phase wrap.
  - Otherwise, the state enters IDLE on the 1->0 toggle.
REQ-024 If run returns to 1 while in STOP, the block SHALL still complete the stop to IDLE, then re-enter RUN on the next cycle.
REQ-025 clk_out SHALL be 0 in IDLE at all times.
REQ-026 rise_stb SHALL assert in the same cycle clk_out first reads 1, and never in IDLE.
REQ-027 div_q==1 SHALL produce clk_out toggling every cycle (period 2).

Reset
REQ-028 On rst_n low, the block SHALL immediately force the following, regardless of the clock:
  - state IDLE, div_q=1, phase=0, pending cleared;
  - clk_out=0, rise_stb=0, cfg_err=0, busy=0, cfg_ready=1, edge_cnt=0.
REQ-029 Reset asserted mid-period SHALL truncate clk_out low at once; after release, operation resumes from IDLE.

Configuration
REQ-030 Macro CLK_GEN_CTRL_EDGE_CNT_EN SHALL control the edge counter.
  - Defined: edge_cnt increments on each rise_stb and wraps from 2^CNT_W-1 to 0.
  - Undefined: port edge_cnt and its counter are absent; all other behaviour is identical.

Verification
REQ-031 Reset, then cfg_div=3 in IDLE, then run=1 -> clk_out period 6 cycles, high 3 / low 3, one rise_stb per period, busy=1.
REQ-032 In RUN with div_q=4, send cfg_div=1 while clk_out=1 -> cfg_ready low until the next 1->0 toggle; then period 2, with no high pulse <4 cycles before the switch.
REQ-033 cfg_div=0 in IDLE or RUN -> cfg_err pulses one cycle, div_q and period unchanged.
REQ-034 run drops 1 cycle after a rise with div_q=5 -> clk_out stays high 5 cycles total, then IDLE with clk_out=0 and busy=0.
REQ-035 rst_n low mid-high-phase -> clk_out=0 asynchronously; after release, div_q=1 and cfg_ready=1.
REQ-036 With CLK_GEN_CTRL_EDGE_CNT_EN, CNT_W=4, div_q=1, 17 rises -> edge_cnt=1 (wrapped).
